// File: rtl/adder_pkg.sv
// Shared types and default sizing for the pipelined add/subtract unit.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int ADDER_WIDTH_DEF  = 4;
  localparam int ADDER_STAGES_DEF = 2;

endpackage

// File: rtl/adder_slice.sv
// One elastic register slice of the adder pipeline: a valid bit plus a data
// word that refills whenever it is empty or its contents are moving on.
module adder_slice
  import adder_pkg::*;
#(
  parameter int DW = ADDER_WIDTH_DEF + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  input  logic          down_ready,
  output logic          valid,
  output logic [DW-1:0] data
);

  // Bubbles collapse: an empty slice always accepts, a full one only while draining.
  assign up_ready = !valid || down_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Elastic pipelined add/subtract unit with valid/ready on both sides.
// Define ADDER_CNT_EN to add the done_cnt completed-transfer counter.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = ADDER_WIDTH_DEF,
  parameter int STAGES = ADDER_STAGES_DEF,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef ADDER_CNT_EN
  ,
  output logic [CNT_W-1:0] done_cnt
`endif
);

  if (WIDTH < 1 || STAGES < 1 || STAGES > 4 || CNT_W < 1) begin : g_bad_param
    $error("adder_pipe: unsupported WIDTH/STAGES/CNT_W");
  end

  logic [WIDTH:0] result;
  logic           stage_valid [STAGES];
  logic [WIDTH:0] stage_data  [STAGES];
  logic           stage_ready [STAGES];

  // Subtraction wraps modulo 2^(WIDTH+1) so the MSB doubles as the borrow flag.
  always_comb begin
    result = {1'b0, a} + {1'b0, b};
    if (op_e'(op) == OP_SUB) begin
      result = {1'b0, a} - {1'b0, b};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic           up_valid;
    logic [WIDTH:0] up_data;
    logic           down_ready;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = result;
    end else begin : g_body
      assign up_valid = stage_valid[k-1];
      assign up_data  = stage_data[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_link
      assign down_ready = stage_ready[k+1];
    end

    adder_slice #(
      .DW(WIDTH + 1)
    ) u_slice (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .up_ready  (stage_ready[k]),
      .down_ready(down_ready),
      .valid     (stage_valid[k]),
      .data      (stage_data[k])
    );
  end

  // Gated by rst so producers never see a ready that reset would swallow.
  assign in_ready  = stage_ready[0] && !rst;
  assign out_valid = stage_valid[STAGES-1];
  assign sum       = stage_data[STAGES-1];

`ifdef ADDER_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe (WIDTH=4, STAGES=2, CNT_W=4).
module tb_adder_pipe;
  import adder_pkg::*;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       op;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] sum;
`ifdef ADDER_CNT_EN
  logic [3:0] done_cnt;
`endif

  int checks = 0;
  int passes = 0;

  adder_pipe #(
    .WIDTH (4),
    .STAGES(2),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
`ifdef ADDER_CNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      passes++;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] aa, input logic [3:0] bb, input logic oo);
    in_valid = v;
    a        = aa;
    b        = bb;
    op       = oo;
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp_q [$];
  logic [3:0] ra, rb;
  logic       rop;
  logic [4:0] exp_val;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);

    #2;
    checkOutput("reset in_ready", in_ready, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset sum", sum, 0);
`ifdef ADDER_CNT_EN
    checkOutput("reset done_cnt", done_cnt, 0);
`endif
    step();
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", in_ready, 1);

    // Basic add: 9 + 8 = 17, visible after two edges.
    step();
    applyStimulus(1'b1, 4'd9, 4'd8, OP_ADD);
    #1;
    checkOutput("add in_ready", in_ready, 1);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);
    checkOutput("add latency out_valid early", out_valid, 0);
    step();
    checkOutput("add out_valid", out_valid, 1);
    checkOutput("add sum", sum, 17);
    checkOutput("add in_ready held", in_ready, 1);
    step();
    checkOutput("add drained", out_valid, 0);

    // Subtract with borrow, then without, back to back.
    applyStimulus(1'b1, 4'd3, 4'd5, OP_SUB);
    step();
    applyStimulus(1'b1, 4'd12, 4'd4, OP_SUB);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);
    checkOutput("sub borrow valid", out_valid, 1);
    checkOutput("sub borrow sum", sum, 5'b11110);
    step();
    checkOutput("sub plain valid", out_valid, 1);
    checkOutput("sub plain sum", sum, 5'b01000);
    step();
    checkOutput("sub drained", out_valid, 0);

    // Backpressure: two beats fill the pipe, third waits.
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd1, 4'd1, OP_ADD);
    #1;
    checkOutput("bp ready beat1", in_ready, 1);
    step();
    applyStimulus(1'b1, 4'd2, 4'd2, OP_ADD);
    #1;
    checkOutput("bp ready beat2", in_ready, 1);
    step();
    applyStimulus(1'b1, 4'd3, 4'd3, OP_ADD);
    #1;
    checkOutput("bp full in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("bp stall valid", out_valid, 1);
      checkOutput("bp stall sum", sum, 2);
      checkOutput("bp stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp release in_ready", in_ready, 1);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);
    checkOutput("bp second valid", out_valid, 1);
    checkOutput("bp second sum", sum, 4);
    step();
    checkOutput("bp third valid", out_valid, 1);
    checkOutput("bp third sum", sum, 6);
    step();
    checkOutput("bp drained", out_valid, 0);

    // Streaming: 20 random beats back to back against a reference model.
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        ra  = 4'($urandom_range(0, 15));
        rb  = 4'($urandom_range(0, 15));
        rop = 1'($urandom_range(0, 1));
        exp_val = rop ? 5'(({1'b0, ra} - {1'b0, rb}) & 5'h1f) : 5'({1'b0, ra} + {1'b0, rb});
        exp_q.push_back(exp_val);
        applyStimulus(1'b1, ra, rb, rop);
        #1;
        checkOutput("stream in_ready", in_ready, 1);
      end else begin
        applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);
      end
      step();
      if (c >= 1 && c <= 20) begin
        checkOutput("stream out_valid", out_valid, 1);
        if (exp_q.size() > 0) begin
          exp_val = exp_q.pop_front();
          checkOutput("stream sum", sum, exp_val);
        end else begin
          checkOutput("stream model underflow", 1, 0);
        end
      end else begin
        checkOutput("stream idle", out_valid, 0);
      end
    end
    checkOutput("stream leftover", exp_q.size(), 0);

    // Reset mid-operation with two beats in flight.
    out_ready = 1'b0;
    applyStimulus(1'b1, 4'd5, 4'd5, OP_ADD);
    step();
    applyStimulus(1'b1, 4'd6, 4'd6, OP_ADD);
    step();
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);
    checkOutput("midrst pre valid", out_valid, 1);
    checkOutput("midrst pre sum", sum, 10);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", out_valid, 0);
    checkOutput("midrst sum", sum, 0);
    checkOutput("midrst in_ready", in_ready, 0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("midrst release in_ready", in_ready, 1);
    step();
    checkOutput("midrst no stale 1", out_valid, 0);
    step();
    checkOutput("midrst no stale 2", out_valid, 0);

`ifdef ADDER_CNT_EN
    // 17 handshaked beats into a 4-bit counter wraps to 1.
    rst = 1'b1;
    #1;
    checkOutput("cnt cleared", done_cnt, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 4'(i), 4'd1, OP_ADD);
      step();
    end
    applyStimulus(1'b0, 4'd0, 4'd0, OP_ADD);
    step();
    step();
    step();
    checkOutput("cnt wrap", done_cnt, 1);
    checkOutput("cnt drained", out_valid, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
